// File: rtl/seq_divider_8bit_pkg.sv
// Shared definitions for the sequential divider.
// Holds the controller state encoding and the default operand width.
package seq_divider_8bit_pkg;

   localparam int WIDTH_DEFAULT = 8;

   // 2'd3 is unused; the controller treats it as IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/add_sub_nbit.sv
// N-bit two's complement adder/subtractor built from a ripple chain of
// full_adder cells. sub=1 computes a-b as a + ~b + 1.
// Ports: a, b - operands
//        sub  - 1: subtract, 0: add
//        sum  - N-bit result; the carry out of the MSB is discarded
module add_sub_nbit #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] sum
);

   logic [N-1:0] b_eff;
   logic [N-1:0] carry;

   assign b_eff    = b ^ {N{sub}};
   assign carry[0] = sub;

   for (genvar i = 0; i < N - 1; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (b_eff[i]),
         .cin  (carry[i]),
         .sum  (sum[i]),
         .cout (carry[i+1])
      );
   end

   // The top bit needs no carry out, so it is a plain sum bit.
   assign sum[N-1] = a[N-1] ^ b_eff[N-1] ^ carry[N-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Ports: a, b, cin - addend bits and carry in
//        sum, cout - sum bit and carry out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential unsigned radix-2 non-restoring divider, one quotient bit per
// clock with a left-shifting partial remainder and a final sign fix-up.
// Ports: clk, rst (synchronous, active low)
//        start, dividend, divisor - request and operands (latched on accept)
//        busy        - operation in progress
//        done        - one-cycle completion pulse
//        quotient, remainder, div_by_zero - results, held until next completion
module seq_divider_8bit
   import seq_divider_8bit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state, state_next;
   logic [WIDTH:0]   a, a_next;       // signed partial remainder
   logic [WIDTH-1:0] q, q_next;       // dividend out, quotient in
   logic [WIDTH-1:0] m, m_next;       // divisor
   logic [CW-1:0]    cnt, cnt_next;
   logic             busy_next, done_next, dbz_next;
   logic [WIDTH-1:0] quotient_next, remainder_next;

   logic [WIDTH:0]   add_x, add_sum;
   logic             add_sub;

   // One adder serves both phases: RUN shifts then adds/subtracts M
   // depending on the sign of A; FIX adds M back only if A is negative.
   always_comb begin
      add_x   = a;
      add_sub = 1'b0;
      if (state == RUN) begin
         add_x   = {a[WIDTH-1:0], q[WIDTH-1]};
         add_sub = ~a[WIDTH];
      end
   end

   add_sub_nbit #(.N(WIDTH + 1)) u_add_sub (
      .a   (add_x),
      .b   ({1'b0, m}),
      .sub (add_sub),
      .sum (add_sum)
   );

   // NOTE: every signal is given a default before the case so no path
   // leaves it unassigned; a missing default would infer a latch.
   always_comb begin
      state_next     = state;
      a_next         = a;
      q_next         = q;
      m_next         = m;
      cnt_next       = cnt;
      busy_next      = busy;
      done_next      = 1'b0;
      dbz_next       = div_by_zero;
      quotient_next  = quotient;
      remainder_next = remainder;

      case (state)
         IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  done_next      = 1'b1;
                  dbz_next       = 1'b1;
                  quotient_next  = '1;
                  remainder_next = dividend;
               end else begin
                  a_next     = '0;
                  q_next     = dividend;
                  m_next     = divisor;
                  cnt_next   = CW'(WIDTH);
                  busy_next  = 1'b1;
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            a_next   = add_sum;
            q_next   = {q[WIDTH-2:0], ~add_sum[WIDTH]};
            cnt_next = cnt - 1'b1;
            if (cnt == CW'(1)) state_next = FIX;
         end
         FIX: begin
            if (a[WIDTH]) a_next = add_sum;
            quotient_next  = q;
            remainder_next = a[WIDTH] ? add_sum[WIDTH-1:0] : a[WIDTH-1:0];
            dbz_next       = 1'b0;
            done_next      = 1'b1;
            busy_next      = 1'b0;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   // NOTE: all state, including the datapath registers, is cleared on
   // reset so an aborted operation leaves nothing behind.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         a           <= '0;
         q           <= '0;
         m           <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
      end else begin
         state       <= state_next;
         a           <= a_next;
         q           <= q_next;
         m           <= m_next;
         cnt         <= cnt_next;
         busy        <= busy_next;
         done        <= done_next;
         div_by_zero <= dbz_next;
         quotient    <= quotient_next;
         remainder   <= remainder_next;
      end
   end

endmodule
